sprite_move_ctrl: RTL

Frame-paced movement controller for one sprite. It samples the direction buttons once every DIV frames and applies a clamped STEP move to the sprite X/Y coordinates. It then pushes the new position to the sprite register bank over a req/ack write handshake. It sits between the button/debounce logic and the sprite register bank, and is the sequencer for the sprite-movement datapath.

---
 rtl/sprite_move_pkg.sv | 40 ++++
 rtl/sprite_move_ctrl_step.sv | 46 ++++
 rtl/sprite_move_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sprite_move_pkg.sv
// Shared definitions for the sprite movement controller: FSM state encoding,
// direction codes, default coordinate width and the button priority encoder.
package sprite_move_pkg;

    // Default width of one sprite coordinate
    localparam int COORD_W_DEFAULT = 10;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_MOVE   = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    // Direction codes as seen on the dir output
    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_LEFT  = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_UP    = 3'd3;
    localparam logic [2:0] DIR_DOWN  = 3'd4;

    // Fixed-priority button encoder: left > right > up > down
    function automatic logic [2:0] sample_dir(input logic left, input logic right,
                                              input logic up, input logic down);
        logic [2:0] d;
        d = DIR_NONE;
        if (left) begin
            d = DIR_LEFT;
        end else if (right) begin
            d = DIR_RIGHT;
        end else if (up) begin
            d = DIR_UP;
        end else if (down) begin
            d = DIR_DOWN;
        end
        return d;
    endfunction

endpackage

// File: rtl/sprite_move_ctrl_step.sv
// Combinational saturating step for one axis. The X instance reacts to
// left/right, the Y instance to up/down. All comparisons are done one bit
// wider than the coordinate so nothing wraps near the ends of the range.
module sprite_coord_step
    import sprite_move_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT,
    parameter int STEP    = 4,
    parameter bit IS_X    = 1'b1
) (
    input  logic [COORD_W-1:0] coord,
    input  logic [2:0]         dir,
    input  logic [COORD_W-1:0] min_val,
    input  logic [COORD_W-1:0] max_val,
    output logic [COORD_W-1:0] next_coord,
    output logic               changed
);

    localparam logic [COORD_W:0]   STEP_EXT = (COORD_W+1)'(STEP);
    localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);

    logic             dec;
    logic             inc;
    logic [COORD_W:0] coord_ext;
    logic [COORD_W:0] lo_limit;
    logic [COORD_W:0] hi_sum;

    // Clamp the stepped coordinate to [min_val, max_val] and flag any change
    always_comb begin
        dec        = IS_X ? (dir == DIR_LEFT)  : (dir == DIR_UP);
        inc        = IS_X ? (dir == DIR_RIGHT) : (dir == DIR_DOWN);
        coord_ext  = {1'b0, coord};
        // coord - min < STEP  <=>  coord < min + STEP (no underflow)
        lo_limit   = {1'b0, min_val} + STEP_EXT;
        // max - coord < STEP  <=>  coord + STEP > max (no overflow)
        hi_sum     = coord_ext + STEP_EXT;
        next_coord = coord;
        if (dec) begin
            next_coord = (coord_ext < lo_limit) ? min_val : (coord - STEP_C);
        end else if (inc) begin
            next_coord = (hi_sum > {1'b0, max_val}) ? max_val : hi_sum[COORD_W-1:0];
        end
        changed = (next_coord != coord);
    end

endmodule

// File: rtl/sprite_move_ctrl.sv
// Frame-paced sprite movement sequencer. Every DIV frame ticks it samples the
// direction buttons, applies one clamped STEP move and pushes the new
// position to the sprite register bank over a req/ack write.
module sprite_move_ctrl
    import sprite_move_pkg::*;
#(
    parameter int         COORD_W     = COORD_W_DEFAULT,
    parameter int         X_MIN       = 0,
    parameter int         X_MAX       = 620,
    parameter int         Y_MIN       = 0,
    parameter int         Y_MAX       = 460,
    parameter int         STEP        = 4,
    parameter int         X_INIT      = 320,
    parameter int         Y_INIT      = 240,
    parameter int         DIV         = 2,
    parameter logic [4:0] SPRITE_ADDR = 5'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 left,
    input  logic                 right,
    input  logic                 up,
    input  logic                 down,
    input  logic                 frame_tick,
    input  logic                 wr_ack,
    output logic                 wr_req,
    output logic [4:0]           wr_addr,
    output logic [2*COORD_W-1:0] wr_data,
    output logic [COORD_W-1:0]   sprite_x,
    output logic [COORD_W-1:0]   sprite_y,
    output logic [2:0]           dir,
    output logic                 busy,
    output logic                 overrun
);

    // A one-bit divider is kept even for DIV=1; it then never increments
    localparam int                 DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [COORD_W-1:0] X_MIN_C  = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] X_MAX_C  = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_MIN_C  = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] Y_MAX_C  = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0] X_INIT_C = COORD_W'(X_INIT);
    localparam logic [COORD_W-1:0] Y_INIT_C = COORD_W'(Y_INIT);

    state_t             state_reg;
    logic [DIV_W-1:0]   div_cnt_reg;
    logic [COORD_W-1:0] x_reg;
    logic [COORD_W-1:0] y_reg;
    logic [2:0]         dir_reg;
    logic               wr_req_reg;
    logic               overrun_reg;

    logic [2:0]         sampled_dir;

    // Per-axis step datapath: index 0 is X, index 1 is Y
    logic [COORD_W-1:0] axis_cur  [2];
    logic [COORD_W-1:0] axis_lo   [2];
    logic [COORD_W-1:0] axis_hi   [2];
    logic [COORD_W-1:0] axis_next [2];
    logic               axis_chg  [2];

    assign axis_cur[0] = x_reg;
    assign axis_cur[1] = y_reg;
    assign axis_lo[0]  = X_MIN_C;
    assign axis_lo[1]  = Y_MIN_C;
    assign axis_hi[0]  = X_MAX_C;
    assign axis_hi[1]  = Y_MAX_C;

    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
        sprite_coord_step #(
            .COORD_W (COORD_W),
            .STEP    (STEP),
            .IS_X    (gi == 0)
        ) u_step (
            .coord      (axis_cur[gi]),
            .dir        (dir_reg),
            .min_val    (axis_lo[gi]),
            .max_val    (axis_hi[gi]),
            .next_coord (axis_next[gi]),
            .changed    (axis_chg[gi])
        );
    end

    assign sampled_dir = sample_dir(left, right, up, down);

    // Sequencer: frame divider, button sampling, clamped move and write handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            div_cnt_reg <= '0;
            x_reg       <= X_INIT_C;
            y_reg       <= Y_INIT_C;
            dir_reg     <= DIR_NONE;
            wr_req_reg  <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            // Ticks that arrive while a move is in flight are dropped and flagged
            overrun_reg <= frame_tick && (state_reg != ST_IDLE);
            case (state_reg)
                ST_IDLE: begin
                    if (frame_tick) begin
                        if (div_cnt_reg == DIV_LAST) begin
                            div_cnt_reg <= '0;
                            state_reg   <= ST_SAMPLE;
                        end else begin
                            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                        end
                    end
                end
                ST_SAMPLE: begin
                    // dir is frozen here so later button changes cannot alter the move
                    dir_reg   <= sampled_dir;
                    state_reg <= (sampled_dir == DIR_NONE) ? ST_IDLE : ST_MOVE;
                end
                ST_MOVE: begin
                    // Already sitting on the bound: nothing to tell the register bank
                    if (axis_chg[0] || axis_chg[1]) begin
                        x_reg      <= axis_next[0];
                        y_reg      <= axis_next[1];
                        wr_req_reg <= 1'b1;
                        state_reg  <= ST_WRITE;
                    end else begin
                        state_reg  <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    // Request and payload hold until the bank acknowledges
                    if (wr_ack) begin
                        wr_req_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_req   = wr_req_reg;
    assign wr_addr  = SPRITE_ADDR;
    assign wr_data  = {x_reg, y_reg};
    assign sprite_x = x_reg;
    assign sprite_y = y_reg;
    assign dir      = dir_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign overrun  = overrun_reg;

endmodule
